st_lvl1_accum: RTL and testbench
================================

# st_lvl1_accum

Sequential consumer of the level-1 shift-and-add results in the ST tensor datapath. It takes a stream of unnormalized {mantissa, exponent, sign} partial sums, aligns each one to a common fixed-point grid, and accumulates them over one dot-product group. At the end of the group it normalizes the sum and presents it downstream with a valid/ready handshake. It sits directly after the level-1 adder and feeds the scale/rounding stage.

## Interface
- ACC_W, 24, accumulator width in bits, two's complement; must be ≥ 16
- BLOCK_LEN, 8, maximum number of beats per group; a group auto-closes on the BLOCK_LEN-th beat
- SHIFT_MAX, ACC_W-11, largest alignment shift that is applied without overflow
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_mant  in  10  unsigned unnormalized mantissa from level 1
- in_exp  in  6  exponent of the beat; bias already removed, so value = mant·2^exp
- in_sign  in  1  1 = negative
- in_last  in  1  final beat of the group
- prec_mode  in  2  2'b11 = FP4 mode (in_exp ignored, treated as 0); other values = INT8/FP8 mode
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_sign  out  1  sign of the sum
- out_mant  out  ACC_W-1  |sum| left-justified: leading one at bit ACC_W-2
- out_exp  out  6  bit index of the leading one of |sum|; 0 when the sum is zero
- out_zero  out  1  sum == 0
- out_ovf  out  1  overflow occurred in the group (sticky per group)
- out_count  out  $clog2(BLOCK_LEN+1)  number of beats in the group

## Operation
- FSM states: ACC, NORM, HOLD. Reset enters ACC with the accumulator, beat counter, and overflow flag all cleared.
- **ACC:**
  - in_ready = 1. A beat is accepted when in_valid && in_ready.
  - Shift: sh = (prec_mode==2'b11) ? 0 : in_exp.
  - If sh > SHIFT_MAX: set the overflow flag and use sh = SHIFT_MAX.
  - Term: t = ±(in_mant << sh), sign-extended to ACC_W bits.
  - acc ← acc + t. Counter increments.
  - Signed overflow of the add sets the overflow flag.
  - Transition to NORM on an accepted beat with in_last = 1, or on the beat where counter+1 == BLOCK_LEN. Both conditions in the same beat are treated as a single close.
- **NORM** (exactly 1 cycle):
  - mag = |acc|, computed in ACC_W bits; the most negative value saturates to 2^(ACC_W-1)-1 and sets ovf.
  - Leading-one index p; out_mant = mag << (ACC_W-2-p); out_exp = p.
  - Zero case: out_mant = 0, out_exp = 0, out_zero = 1, out_sign = 0.
  - Result registers are loaded, then go to HOLD.
- **HOLD:**
  - out_valid = 1; all out_* stay stable.
  - On out_ready: clear acc, counter, and flag, then go to ACC.
- in_ready = 0 in NORM and HOLD. in_* are ignored while in_ready = 0.
- Reset mid-group discards partial state; no output is produced.

## Timing
- Reset values: in_ready = 0 during reset and 1 from the first cycle after. out_valid, out_sign, out_mant, out_exp, out_zero, out_ovf, out_count are all 0.
- A beat accepted at cycle n is in acc at n+1.
- Closing beat accepted at n: NORM at n+1, out_valid = 1 at n+2.
- Output handshake at cycle m: out_valid = 0 and in_ready = 1 at m+1. No combinational path from out_ready to in_ready.
- Minimum group period: beats + 2 cycles.
- No throughput loss between back-to-back beats in ACC.

## Configuration
- ST_ACC_SATURATE_EN:
  - Defined: accumulation saturates to +2^(ACC_W-1)-1 or -2^(ACC_W-1) on overflow, and ovf is set.
  - Undefined: accumulation wraps in two's complement; ovf is still set on overflow.
  - Alignment-shift clamping (sh > SHIFT_MAX) behaves the same in both builds.

## Test plan
- Reset: assert rst 3 cycles → all out_* = 0, in_ready = 0 during reset and 1 on the first cycle after.
- FP4 mode: beats (5,+), (3,−), (10,+ last), each with in_exp = 6 → out_valid 2 cycles after the last accept; out_sign = 0, out_exp = 3, out_mant = 0x600000, out_count = 3, out_ovf = 0.
- INT8 mode auto-close: 8 beats with no in_last; beat0 (100, exp 2, +), beat1 (50, exp 0, −), beats 2–7 (0) → closes after the 8th beat; out_exp = 8, out_mant = 350<<14, out_count = 8.
- Cancellation: (7, exp 1, +) then (14, exp 0, − last) → out_zero = 1, out_sign = 0, out_exp = 0, out_mant = 0.
- Backpressure: hold out_ready = 0 for 5 cycles in HOLD → outputs stable and in_ready = 0; raise out_ready → in_ready = 1 the next cycle, and the next group accumulates from 0.
- Overflow: in_exp = 20 (> 13) with mant 1023 repeated 8× → out_ovf = 1. With ST_ACC_SATURATE_EN: out_mant = 0x7FFFFF, out_exp = 22. Without it: out_mant and out_exp match the wrapped two's-complement sum.

Source files
------------

// File: rtl/st_lvl1_accum.sv
// Level-1 partial-sum accumulator: aligns {mant,exp,sign} beats onto a fixed-point
// grid, sums one group, then normalizes. Optional build macro: ST_ACC_SATURATE_EN.
module st_lvl1_accum #(
  parameter int ACC_W     = 24,
  parameter int BLOCK_LEN = 8,
  parameter int SHIFT_MAX = ACC_W - 11,
  localparam int CNT_W    = $clog2(BLOCK_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_mant,
  input  logic [5:0]       in_exp,
  input  logic             in_sign,
  input  logic             in_last,
  input  logic [1:0]       prec_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [ACC_W-2:0] out_mant,
  output logic [5:0]       out_exp,
  output logic             out_zero,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [1:0] S_ACC  = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [5:0]       SH_MAX  = 6'(SHIFT_MAX);
  localparam logic [5:0]       TOP_BIT = 6'(ACC_W - 2);

  logic [1:0]       r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_in_rdy;
  logic             r_out_valid;

  logic             w_accept, w_clamp, w_add_ovf, w_close;
  logic [5:0]       w_sh_raw, w_sh;
  logic [ACC_W-1:0] w_mag_t, w_term, w_acc_nxt;
  logic [ACC_W:0]   w_sum;
  logic [CNT_W-1:0] w_cnt_inc;

  // Alignment and accumulation
  assign w_accept  = in_valid && r_in_rdy && (r_state == S_ACC);
  assign w_sh_raw  = (prec_mode == 2'b11) ? 6'd0 : in_exp;
  assign w_clamp   = w_sh_raw > SH_MAX;
  assign w_sh      = w_clamp ? SH_MAX : w_sh_raw;
  assign w_mag_t   = {{(ACC_W-10){1'b0}}, in_mant} << w_sh;
  assign w_term    = in_sign ? (~w_mag_t + 1'b1) : w_mag_t;
  assign w_sum     = {r_acc[ACC_W-1], r_acc} + {w_term[ACC_W-1], w_term};
  assign w_add_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_close   = in_last || (w_cnt_inc == CNT_W'(BLOCK_LEN));

`ifdef ST_ACC_SATURATE_EN
  // The extra sum bit carries the true sign, so it picks the saturation rail.
  assign w_acc_nxt = w_add_ovf ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];
`else
  assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

  // Normalization of the finished group
  logic             w_is_min, w_zero;
  logic [ACC_W-1:0] w_mag, w_norm;
  logic [5:0]       w_lead;

  assign w_is_min = (r_acc == ACC_MIN);
  assign w_zero   = (r_acc == '0);
  assign w_mag    = w_is_min ? ACC_MAX : (r_acc[ACC_W-1] ? (~r_acc + 1'b1) : r_acc);

  always_comb begin
    w_lead = '0;
    for (int i = 0; i < ACC_W - 1; i++)
      if (w_mag[i]) w_lead = 6'(i);
  end

  assign w_norm = w_mag << (TOP_BIT - w_lead);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACC:   if (w_accept && w_close) w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) w_state_nxt = S_ACC;
      default: w_state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_rdy    <= 1'b0;
      r_out_valid <= 1'b0;
      out_sign    <= 1'b0;
      out_mant    <= '0;
      out_exp     <= '0;
      out_zero    <= 1'b0;
      out_ovf     <= 1'b0;
      out_count   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      // Registered ready keeps out_ready off the in_ready path.
      r_in_rdy <= (w_state_nxt == S_ACC);
      case (r_state)
        S_ACC: if (w_accept) begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_inc;
          if (w_clamp || w_add_ovf) r_ovf <= 1'b1;
        end
        S_NORM: begin
          r_out_valid <= 1'b1;
          out_sign    <= w_zero ? 1'b0 : r_acc[ACC_W-1];
          out_mant    <= w_zero ? '0 : w_norm[ACC_W-2:0];
          out_exp     <= w_zero ? 6'd0 : w_lead;
          out_zero    <= w_zero;
          out_ovf     <= r_ovf | w_is_min;
          out_count   <= r_cnt;
        end
        S_HOLD: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_rdy;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_st_lvl1_accum.sv
// Directed bench for st_lvl1_accum: table of beats with expected group results,
// plus hand sequences for reset, backpressure and mid-group reset.
module tb_st_lvl1_accum;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_sign, in_last, out_valid, out_ready;
  logic [9:0]  in_mant;
  logic [5:0]  in_exp;
  logic [1:0]  prec_mode;
  logic        out_sign, out_zero, out_ovf;
  logic [22:0] out_mant;
  logic [5:0]  out_exp;
  logic [3:0]  out_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  st_lvl1_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign), .in_last(in_last),
    .prec_mode(prec_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_mant(out_mant), .out_exp(out_exp),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_count(out_count)
  );

  typedef struct {
    logic [9:0]  mant;
    logic [5:0]  e;
    logic        sgn, last, fp4, close;
    logic        esgn;
    logic [22:0] emant;
    logic [5:0]  eexp;
    logic        ezero, eovf;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t bt(input int m, input int e, input bit s, input bit l, input bit f);
    vec_t v;
    v = '{default: '0};
    v.mant = 10'(m); v.e = 6'(e); v.sgn = s; v.last = l; v.fp4 = f;
    return v;
  endfunction

  function automatic vec_t cl(input vec_t b, input bit es, input int em, input int ee,
                              input bit ez, input bit eo, input int ec);
    vec_t v;
    v = b;
    v.close = 1'b1; v.esgn = es; v.emant = 23'(em); v.eexp = 6'(ee);
    v.ezero = ez; v.eovf = eo; v.ecnt = 4'(ec);
    return v;
  endfunction

  task automatic beat(input logic [9:0] m, input logic [5:0] e, input bit s, input bit l, input bit f);
    @(negedge clk);
    in_valid = 1'b1; in_mant = m; in_exp = e; in_sign = s; in_last = l;
    prec_mode = f ? 2'b11 : 2'b00;
  endtask

  // Called right after the closing beat is driven; walks NORM, HOLD and the handshake.
  task automatic expect_out(input string name, input bit es, input logic [22:0] em,
                            input logic [5:0] ee, input bit ez, input bit eo, input logic [3:0] ec);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk({name, "_norm_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_sign"},  32'(out_sign),  32'(es));
    chk({name, "_mant"},  32'(out_mant),  32'(em));
    chk({name, "_exp"},   32'(out_exp),   32'(ee));
    chk({name, "_zero"},  32'(out_zero),  32'(ez));
    chk({name, "_ovf"},   32'(out_ovf),   32'(eo));
    chk({name, "_count"}, 32'(out_count), 32'(ec));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_rdy_after"}, 32'(in_ready), 32'd1);
    chk({name, "_vld_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    // FP4: 5 - 3 + 10 = 12, exponent ignored
    tv.push_back(bt(5, 6, 0, 0, 1));
    tv.push_back(bt(3, 6, 1, 0, 1));
    tv.push_back(cl(bt(10, 6, 0, 1, 1), 0, 'h600000, 3, 0, 0, 3));
    // INT8 auto-close: 400 - 50 = 350
    tv.push_back(bt(100, 2, 0, 0, 0));
    tv.push_back(bt(50, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++) tv.push_back(bt(0, 0, 0, 0, 0));
    tv.push_back(cl(bt(0, 0, 0, 0, 0), 0, 350 << 14, 8, 0, 0, 8));
    // Cancellation to zero
    tv.push_back(bt(7, 1, 0, 0, 0));
    tv.push_back(cl(bt(14, 0, 1, 1, 0), 0, 0, 0, 1, 0, 2));
    // Negative single beat
    tv.push_back(cl(bt(5, 0, 1, 1, 0), 1, 'h500000, 2, 0, 0, 1));
    // Shift clamp: exp 40 -> 13, flags ovf, no add overflow
    tv.push_back(cl(bt(1, 40, 0, 1, 0), 0, 'h400000, 13, 0, 1, 1));
    // Most negative sum saturates in the magnitude
    tv.push_back(bt(1023, 13, 1, 0, 0));
    tv.push_back(cl(bt(1, 13, 1, 1, 0), 1, 'h7FFFFF, 22, 0, 1, 2));
    // in_last together with the BLOCK_LEN-th beat is one close
    for (int i = 0; i < 7; i++) tv.push_back(bt(1, 0, 0, 0, 0));
    tv.push_back(cl(bt(1, 0, 0, 1, 0), 0, 'h400000, 3, 0, 0, 8));
    tv.push_back(cl(bt(2, 0, 0, 1, 0), 0, 'h400000, 1, 0, 0, 1));
    // Accumulator overflow: 8 x (1023 << 13)
    for (int i = 0; i < 7; i++) tv.push_back(bt(1023, 20, 0, 0, 0));
`ifdef ST_ACC_SATURATE_EN
    tv.push_back(cl(bt(1023, 20, 0, 0, 0), 0, 'h7FFFFF, 22, 0, 1, 8));
`else
    tv.push_back(cl(bt(1023, 20, 0, 0, 0), 1, 'h400000, 16, 0, 1, 8));
`endif

    rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; in_sign = 1'b0;
    in_last = 1'b0; prec_mode = 2'b00; out_ready = 1'b0;

    // Reset
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_fields", {out_sign, out_zero, out_ovf, out_exp, out_count},  32'd0);
    chk("rst_out_mant", 32'(out_mant), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    foreach (tv[i]) begin
      beat(tv[i].mant, tv[i].e, tv[i].sgn, tv[i].last, tv[i].fp4);
      if (tv[i].close)
        expect_out($sformatf("vec%0d", i), tv[i].esgn, tv[i].emant, tv[i].eexp,
                   tv[i].ezero, tv[i].eovf, tv[i].ecnt);
    end

    // Backpressure: 9 -> exp 3, mant 9<<19; junk input during HOLD must be ignored
    beat(9, 0, 0, 1, 0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("bp_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_mant = 10'd1023; in_exp = 6'd5;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_mant", 32'(out_mant), 32'h480000);
      chk("bp_hold_exp", 32'(out_exp), 32'd3);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    beat(3, 0, 0, 1, 0);
    expect_out("bp_next", 0, 23'h600000, 6'd1, 0, 0, 4'd1);

    // Reset mid-group discards the partial sum
    beat(100, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    beat(3, 0, 0, 1, 0);
    expect_out("midrst_next", 0, 23'h600000, 6'd1, 0, 0, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
